imem_boot_loader: RTL

//  Upstream stage of the Harvard multi-cycle CPU: fills the instruction RAM before the CPU runs.

---
 rtl/imem_boot_loader_if.sv | 12 +
 rtl/imem_boot_loader.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader_if.sv
// Byte-stream handshake into the IMEM boot loader.
// The source drives data/valid; the loader answers with ready.
interface imem_boot_loader_if #(
    parameter int BYTE_WIDTH = 8
);
    logic [BYTE_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: turns a counted byte stream into sequential IMEM word writes,
// checks the trailing XOR checksum and releases cpu_reset when it matches.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_LEN_HI  | waiting for the high byte of the word count
// S_LEN_LO  | waiting for the low byte; range-checks the full count
// S_DATA_HI | waiting for the high byte of the next instruction word
// S_DATA_LO | waiting for the low byte of the instruction word
// S_WRITE   | one-cycle IMEM write of the assembled word
// S_CHECK   | waiting for the checksum byte
// S_DONE    | load good, CPU released; reload restarts
// S_ERROR   | load aborted, CPU held; reload restarts
module imem_boot_loader #(
    parameter int ADDRESS_BUS_WIDTH = 12,
    parameter int INSTRUCTION_WIDTH = 16,
    parameter int BYTE_WIDTH        = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    imem_boot_loader_if.slave            stream,
    input  logic                         reload,
    output logic [ADDRESS_BUS_WIDTH-1:0] imem_addr,
    output logic [INSTRUCTION_WIDTH-1:0] imem_wdata,
    output logic                         imem_we,
    output logic                         cpu_reset,
    output logic                         done,
    output logic                         error
);

    localparam int LEN_W = 2 * BYTE_WIDTH;
    localparam logic [LEN_W:0] CAPACITY = (LEN_W + 1)'(2 ** ADDRESS_BUS_WIDTH);

    typedef enum logic [2:0] {
        S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO,
        S_WRITE, S_CHECK, S_DONE, S_ERROR
    } state_t;

    state_t                   state, state_next;
    logic [LEN_W-1:0]         count;
    logic [LEN_W-1:0]         count_full;
    logic [ADDRESS_BUS_WIDTH:0] words;
    logic [BYTE_WIDTH-1:0]    checksum;
    logic                     transfer;
    logic                     last_word;

    assign transfer   = stream.in_valid & stream.in_ready;
    assign count_full = {count[LEN_W-1 -: BYTE_WIDTH], stream.in_data};
    // words holds the count already written before this WRITE completes
    assign last_word  = (LEN_W'(words) + LEN_W'(1)) >= count;

    always_ff @(posedge clock) begin
        if (reset) state <= S_LEN_HI;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_LEN_HI:  if (transfer) state_next = S_LEN_LO;
            S_LEN_LO:
                if (transfer) begin
                    if (count_full == '0)                  state_next = S_CHECK;
                    else if ({1'b0, count_full} > CAPACITY) state_next = S_ERROR;
                    else                                   state_next = S_DATA_HI;
                end
            S_DATA_HI: if (transfer) state_next = S_DATA_LO;
            S_DATA_LO: if (transfer) state_next = S_WRITE;
            S_WRITE:   state_next = last_word ? S_CHECK : S_DATA_HI;
            S_CHECK:
                if (transfer)
                    state_next = (stream.in_data == checksum) ? S_DONE : S_ERROR;
            S_DONE, S_ERROR: if (reload) state_next = S_LEN_HI;
            default:   state_next = S_LEN_HI;
        endcase
    end

    always_comb begin
        stream.in_ready = 1'b0;
        imem_we         = 1'b0;
        cpu_reset       = 1'b1;
        done            = 1'b0;
        error           = 1'b0;
        case (state)
            S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK: stream.in_ready = 1'b1;
            S_WRITE: imem_we = 1'b1;
            S_DONE: begin
                cpu_reset = 1'b0;
                done      = 1'b1;
            end
            S_ERROR: error = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            imem_addr  <= '0;
            imem_wdata <= '0;
            count      <= '0;
            words      <= '0;
            checksum   <= '0;
        end else begin
            case (state)
                S_LEN_HI:
                    if (transfer) begin
                        count[LEN_W-1 -: BYTE_WIDTH] <= stream.in_data;
                        checksum <= checksum ^ stream.in_data;
                    end
                S_LEN_LO:
                    if (transfer) begin
                        count[BYTE_WIDTH-1:0] <= stream.in_data;
                        checksum <= checksum ^ stream.in_data;
                    end
                S_DATA_HI:
                    if (transfer) begin
                        imem_wdata[INSTRUCTION_WIDTH-1 -: BYTE_WIDTH] <= stream.in_data;
                        checksum <= checksum ^ stream.in_data;
                    end
                S_DATA_LO:
                    if (transfer) begin
                        imem_wdata[BYTE_WIDTH-1:0] <= stream.in_data;
                        checksum <= checksum ^ stream.in_data;
                    end
                S_WRITE: begin
                    words <= words + 1'b1;
                    // the last word keeps its address so a full IMEM never wraps to 0
                    if (!last_word) imem_addr <= imem_addr + 1'b1;
                end
                S_DONE, S_ERROR:
                    if (reload) begin
                        imem_addr <= '0;
                        count     <= '0;
                        words     <= '0;
                        checksum  <= '0;
                    end
                default: ;
            endcase
        end
    end

endmodule
